uart_msg_sender: RTL and testbench
==================================

Name: uart_msg_sender

Overview:
Parametrised message transmitter that drives the existing UART core's transmit/is_transmitting handshake. It replaces single-byte hard-coded transmission with a DEPTH-byte message buffer that is written through a simple write port. A message of programmable length is sent on a start pulse, in one-shot or repeat mode, with an inter-byte gap, a handshake timeout and abort. It sits between board-level control logic and the UART core.

Parameters:
DEPTH, 16, message buffer depth in bytes (power of two, >=2)
ADDR_W, 4, buffer address width; log2(DEPTH)
GAP_CYCLES, 0, idle clk cycles inserted after each byte completes (0 = none)
ACK_TIMEOUT, 1024, max cycles to wait for is_transmitting to rise after transmit asserts

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  ADDR_W  buffer write address
wr_data  in  8  buffer write data
len  in  ADDR_W+1  message length in bytes, sampled on accepted start
start  in  1  start request, level sampled each cycle
repeat_en  in  1  1 = resend message continuously
abort  in  1  stop at next byte boundary
tx_byte  out  8  byte to UART core
transmit  out  1  transmit request to UART core
is_transmitting  in  1  UART core busy flag
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse at end of each complete message pass
err  out  1  sticky handshake-timeout flag
byte_idx  out  ADDR_W  index of byte currently sent

Behaviour:
- Reset (async, rst_n=0): state IDLE; tx_byte=0, transmit=0, busy=0, done=0, err=0, byte_idx=0. Buffer contents are undefined after reset and are not cleared.
- All outputs are registered. The buffer is synchronous-write; reads are combinational or registered, provided tx_byte is valid when transmit rises.
- Writes are accepted only in IDLE. wr_en while busy=1 is ignored.
- Start accept: in IDLE with start=1, latch L=min(len,DEPTH), clear err, set busy=1 next cycle.
  - If L=0: done pulses the cycle after start; no transmit; return to IDLE.
  - start while busy=1 is ignored.
- States: IDLE, REQ, XMIT, GAP.
- REQ: tx_byte=buf[byte_idx], transmit=1 (asserted the cycle after entering from IDLE/GAP). Transmit is held until is_transmitting is sampled 1; the next cycle transmit=0 and the state goes to XMIT.
  - The timeout counter counts cycles in REQ. Reaching ACK_TIMEOUT without is_transmitting=1: transmit=0, err=1, busy=0, IDLE, no done pulse.
- XMIT: wait for is_transmitting=0. Then:
  - if GAP_CYCLES>0, go to GAP;
  - otherwise advance immediately.
- GAP: count GAP_CYCLES cycles, then advance.
- Advance:
  - byte_idx<L-1: byte_idx+1, REQ.
  - byte_idx=L-1: done=1 for one cycle, then:
    - repeat_en=1 (sampled at this cycle): byte_idx=0, REQ;
    - else busy=0, byte_idx=0, IDLE.
- abort:
  - In REQ before acknowledgement: transmit drops next cycle, IDLE, busy=0.
  - In XMIT/GAP: the current byte finishes (is_transmitting falls), then IDLE without a done pulse.
  - abort is latched until acted upon.
- Simultaneous abort and done on the last byte: abort wins; no done pulse.
- byte_idx wraps only via reset to 0 at message end. It never exceeds L-1.
- err remains set until the next accepted start or reset.
- Reset mid-message: transmit drops asynchronously. Any partially sent byte is the UART core's concern.

Test Plan:
- Write "HELLO" (48 45 4C 4C 4F) to addr 0-4, len=5, start pulse, UART model acks 2 cycles after transmit and is busy for 10 cycles -> exactly 5 transmit handshakes with tx_byte 48,45,4C,4C,4F in order, one done pulse, busy then 0, err=0.
- len=0 start -> done pulses the next cycle, transmit never asserted, busy high at most 1 cycle.
- len=20 with DEPTH=16 -> exactly 16 bytes sent (buf[0..15]), then done.
- repeat_en=1, len=2, GAP_CYCLES=4 -> byte sequence b0,b1,b0,b1,...; done pulses after each pair; at least 4 idle cycles between is_transmitting falling and the next transmit rising. Drop repeat_en -> stop after the current pass completes.
- is_transmitting held 0, ACK_TIMEOUT=16 -> transmit high exactly 16 cycles, then err=1, busy=0, no done; a new start clears err.
- abort asserted mid-byte 2 of 5 -> byte 2 completes, no further transmit, no done, busy=0. rst_n pulsed low mid-REQ -> transmit and busy drop immediately, all outputs at reset values.

Source files
------------

// File: rtl/uart_msg_sender_if.sv
// Transmit handshake between the message sender and the UART core.
// The sender drives byte/request; the core answers with its busy flag.
interface uart_msg_sender_if;
  logic [7:0] tx_byte;
  logic       transmit;
  logic       is_transmitting;

  modport master (
    output tx_byte,
    output transmit,
    input  is_transmitting
  );

  modport slave (
    input  tx_byte,
    input  transmit,
    output is_transmitting
  );
endinterface

// File: rtl/uart_msg_sender.sv
// Buffered multi-byte message transmitter for the UART core handshake.
// One-shot or repeat mode, inter-byte gap, ack timeout and abort.
module uart_msg_sender #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W:0]   len,
  input  logic              start,
  input  logic              repeat_en,
  input  logic              abort,
  uart_msg_sender_if.master uart,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] byte_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XMIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [TW-1:0]   T_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0]   G_LAST  =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  logic [7:0]        mem [DEPTH];
  logic [1:0]        state;
  logic [ADDR_W:0]   len_q;
  logic [TW-1:0]     tcnt;
  logic [GW-1:0]     gcnt;
  logic              abort_q;
  logic [7:0]        tx_byte_q;
  logic              transmit_q;

  logic [ADDR_W:0]   len_sat;
  logic [ADDR_W-1:0] idx_nxt;
  logic              last;
  logic              abort_hit;
  logic              xmit_fin;
  logic              gap_fin;
  logic              kill;
  logic              adv;
  logic              wr_ok;

  assign uart.tx_byte  = tx_byte_q;
  assign uart.transmit = transmit_q;

  always_comb begin
    len_sat   = (len > DEPTH_L) ? DEPTH_L : len;
    idx_nxt   = byte_idx + 1'b1;
    last      = ({1'b0, byte_idx} == (len_q - 1'b1));
    abort_hit = abort | abort_q;
    xmit_fin  = (state == S_XMIT) && !uart.is_transmitting;
    gap_fin   = (state == S_GAP) && (gcnt == G_LAST);
    // a finished byte with a pending abort ends the message, gap or not
    kill      = (xmit_fin || gap_fin) && abort_hit;
    adv       = !abort_hit && (gap_fin || (xmit_fin && !HAS_GAP));
    wr_ok     = wr_en && (state == S_IDLE) && !busy;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len_q      <= '0;
      tcnt       <= '0;
      gcnt       <= '0;
      abort_q    <= 1'b0;
      tx_byte_q  <= '0;
      transmit_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_idx   <= '0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && abort) abort_q <= 1'b1;

      if (kill) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        byte_idx   <= '0;
        abort_q    <= 1'b0;
        transmit_q <= 1'b0;
      end else if (adv) begin
        if (last) begin
          done     <= 1'b1;
          byte_idx <= '0;
          if (repeat_en) begin
            state      <= S_REQ;
            transmit_q <= 1'b1;
            tx_byte_q  <= mem[0];
            tcnt       <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end else begin
          byte_idx   <= idx_nxt;
          state      <= S_REQ;
          transmit_q <= 1'b1;
          tx_byte_q  <= mem[idx_nxt];
          tcnt       <= '0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !busy) begin
              err      <= 1'b0;
              len_q    <= len_sat;
              byte_idx <= '0;
              abort_q  <= 1'b0;
              busy     <= 1'b1;
              // zero-length message: one busy cycle with done, no handshake
              if (len_sat == '0) begin
                done <= 1'b1;
              end else begin
                state      <= S_REQ;
                transmit_q <= 1'b1;
                tx_byte_q  <= mem[0];
                tcnt       <= '0;
              end
            end else begin
              busy <= 1'b0;
            end
          end
          S_REQ: begin
            if (uart.is_transmitting) begin
              transmit_q <= 1'b0;
              state      <= S_XMIT;
            end else if (abort_hit) begin
              transmit_q <= 1'b0;
              state      <= S_IDLE;
              busy       <= 1'b0;
              byte_idx   <= '0;
              abort_q    <= 1'b0;
            end else if (tcnt == T_LAST) begin
              transmit_q <= 1'b0;
              err        <= 1'b1;
              state      <= S_IDLE;
              busy       <= 1'b0;
              byte_idx   <= '0;
              abort_q    <= 1'b0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_XMIT: begin
            if (!uart.is_transmitting) begin
              state <= S_GAP;
              gcnt  <= '0;
            end
          end
          S_GAP: begin
            gcnt <= gcnt + 1'b1;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_msg_sender.sv
// Directed bench for uart_msg_sender with a UART core model
// and a byte scoreboard.
module tb_uart_msg_sender;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          wr_en     = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [7:0]    wr_data   = '0;
  logic [AW:0]   len       = '0;
  logic          start     = 1'b0;
  logic          repeat_en = 1'b0;
  logic          abort     = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] byte_idx;

  uart_msg_sender_if ifc ();

  uart_msg_sender #(
    .DEPTH(DEPTH),
    .ADDR_W(AW),
    .GAP_CYCLES(4),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .len(len),
    .start(start),
    .repeat_en(repeat_en),
    .abort(abort),
    .uart(ifc),
    .busy(busy),
    .done(done),
    .err(err),
    .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] image [DEPTH];
  logic [7:0] exp_q [$];

  bit uart_en = 1'b1;

  int cyc      = 0;
  int fall_cyc = 0;
  int hi_run   = 0;
  int hi_len   = 0;
  int min_gap  = 1000;
  int tx_cnt   = 0;
  int done_cnt = 0;
  bit tx_prev  = 1'b0;
  bit it_prev  = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART core: ack 2 cycles after transmit, busy for 10 cycles
  initial begin
    ifc.is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_en && ifc.transmit) begin
        repeat (2) @(negedge clk);
        ifc.is_transmitting = 1'b1;
        repeat (10) @(negedge clk);
        ifc.is_transmitting = 1'b0;
      end
    end
  end

  // Monitor: scoreboard on each transmit rise, gap and pulse tracking
  always @(posedge clk) begin
    #1;
    cyc++;
    if (ifc.transmit && !tx_prev) begin
      tx_cnt++;
      if (cyc - fall_cyc < min_gap) min_gap = cyc - fall_cyc;
      check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("tx_byte", 32'(ifc.tx_byte), 32'(exp_q.pop_front()));
    end
    if (ifc.transmit) hi_run = tx_prev ? hi_run + 1 : 1;
    if (!ifc.transmit && tx_prev) hi_len = hi_run;
    if (done) done_cnt++;
    if (!ifc.is_transmitting && it_prev) fall_cyc = cyc;
    tx_prev = ifc.transmit;
    it_prev = ifc.is_transmitting;
  end

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [AW:0] l);
    @(negedge clk);
    len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || ifc.is_transmitting) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(n < budget), 32'd1);
  endtask

  int d0;
  int t0;
  int n;

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check("rst_tx_byte", 32'(ifc.tx_byte), 32'h0);
    check("rst_transmit", 32'(ifc.transmit), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_byte_idx", 32'(byte_idx), 32'h0);
    rst_n = 1'b1;

    image[0] = 8'h48; image[1] = 8'h45; image[2] = 8'h4C;
    image[3] = 8'h4C; image[4] = 8'h4F;
    for (int i = 5; i < DEPTH; i++) image[i] = 8'(8'h10 + i);
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), image[i]);

    // HELLO
    d0 = done_cnt; t0 = tx_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(image[i]);
    go(5'd5);
    wait_idle("hello", 2000);
    check("hello_tx_cnt", 32'(tx_cnt - t0), 32'd5);
    check("hello_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("hello_busy", 32'(busy), 32'd0);
    check("hello_err", 32'(err), 32'd0);
    check("hello_q_empty", 32'(exp_q.size()), 32'd0);

    // zero length
    d0 = done_cnt; t0 = tx_cnt;
    @(negedge clk);
    len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", 32'(done), 32'd1);
    @(negedge clk);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_done_low", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    check("len0_tx_cnt", 32'(tx_cnt - t0), 32'd0);
    check("len0_done_cnt", 32'(done_cnt - d0), 32'd1);

    // len beyond depth saturates; write while busy is dropped
    d0 = done_cnt; t0 = tx_cnt;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(image[i]);
    go(5'd20);
    wr(4'd0, 8'hEE);
    wait_idle("len20", 5000);
    check("len20_tx_cnt", 32'(tx_cnt - t0), 32'd16);
    check("len20_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("len20_q_empty", 32'(exp_q.size()), 32'd0);

    // repeat mode, stop after current pass
    d0 = done_cnt; t0 = tx_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(image[0]);
      exp_q.push_back(image[1]);
    end
    repeat_en = 1'b1;
    go(5'd2);
    n = 0;
    while (done_cnt - d0 < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rep_two_passes", 32'(n < 3000), 32'd1);
    repeat_en = 1'b0;
    wait_idle("rep", 3000);
    check("rep_tx_cnt", 32'(tx_cnt - t0), 32'd6);
    check("rep_done_cnt", 32'(done_cnt - d0), 32'd3);
    check("rep_min_gap", 32'(min_gap >= 4), 32'd1);
    check("rep_q_empty", 32'(exp_q.size()), 32'd0);

    // ack timeout
    d0 = done_cnt; t0 = tx_cnt;
    uart_en = 1'b0;
    exp_q.push_back(image[0]);
    go(5'd3);
    wait_idle("tmo", 200);
    check("tmo_hi_len", 32'(hi_len), 32'd16);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("tmo_tx_cnt", 32'(tx_cnt - t0), 32'd1);
    uart_en = 1'b1;
    d0 = done_cnt;
    exp_q.push_back(image[0]);
    go(5'd1);
    check("tmo_err_clear", 32'(err), 32'd0);
    wait_idle("tmo_restart", 500);
    check("tmo_restart_done", 32'(done_cnt - d0), 32'd1);

    // abort during third byte
    d0 = done_cnt; t0 = tx_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back(image[i]);
    go(5'd5);
    n = 0;
    while (!(tx_cnt - t0 == 3 && ifc.is_transmitting) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_b2", 32'(n < 2000), 32'd1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("abort", 500);
    repeat (20) @(negedge clk);
    check("abort_tx_cnt", 32'(tx_cnt - t0), 32'd3);
    check("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_q_empty", 32'(exp_q.size()), 32'd0);

    // reset mid-REQ
    uart_en = 1'b0;
    exp_q.push_back(image[0]);
    go(5'd5);
    @(negedge clk);
    check("mid_transmit", 32'(ifc.transmit), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_transmit", 32'(ifc.transmit), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tx_byte", 32'(ifc.tx_byte), 32'd0);
    check("arst_byte_idx", 32'(byte_idx), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
